// File: rtl/timer_pkg.sv
// Shared types and constants for the water-reminder timer mode controller.
package timer_pkg;

  // Controller modes; the encoding is visible on the mode output.
  typedef enum logic [2:0] {
    RUN     = 3'd0,
    PAUSE   = 3'd1,
    SET_HR  = 3'd2,
    SET_MIN = 3'd3,
    ALERT   = 3'd4
  } mode_t;

  // Ceiling for the missed-alert counter (4-bit output).
  localparam int unsigned MISSED_MAX = 15;

  // True for the two modes in which a clock field is being edited.
  function automatic logic isSetMode(input mode_t m);
    return (m == SET_HR) || (m == SET_MIN);
  endfunction

endpackage

// File: rtl/timer_mode_ctrl_btn_press.sv
// One button: rising-edge detect with a holdoff lockout after each accepted press.
module btn_press #(
  parameter int unsigned HOLDOFF_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_accept
);

  logic       r_prev;
  logic [7:0] r_holdoff;
  logic       w_rise;

  assign w_rise   = i_btn & ~r_prev;
  assign o_accept = w_rise && (r_holdoff == 8'd0);

  // Track the previous level and run the lockout counter down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev    <= 1'b0;
      r_holdoff <= 8'd0;
    end else begin
      r_prev <= i_btn;
      if (o_accept) begin
        r_holdoff <= 8'(HOLDOFF_CYCLES);
      end else if (r_holdoff != 8'd0) begin
        r_holdoff <= r_holdoff - 8'd1;
      end
    end
  end

endmodule

// File: rtl/timer_mode_ctrl.sv
// Mode controller: run/pause/time-set sequencing plus the reminder alert cycle.
module timer_mode_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYCLES = 4,
  parameter int unsigned BLINK_TICKS    = 1,
  parameter int unsigned ALERT_TICKS    = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_ack,
  input  logic       remind,
  output logic       count_en,
  output logic       inc_hours,
  output logic       inc_minutes,
  output logic       clear_seconds,
  output logic [2:0] mode,
  output logic       blink,
  output logic       alert,
  output logic [3:0] missed
);

  mode_t      r_state;
  logic       r_pending;
  logic       r_remindPrev;
  logic [7:0] r_blinkCnt;
  logic [7:0] r_alertCnt;

  mode_t      w_nextState;
  logic       w_modeAcc;
  logic       w_incAcc;
  logic       w_ackAcc;
  logic       w_remindRise;
  logic       w_setPending;
  logic       w_clrPending;
  logic       w_incHoursNext;
  logic       w_incMinutesNext;
  logic       w_clearSecNext;
  logic       w_alertTimeout;
  logic [7:0] w_blinkCntInc;
  logic [7:0] w_alertCntInc;

  btn_press #(.HOLDOFF_CYCLES(HOLDOFF_CYCLES)) u_btnMode (
    .clk      (clk),
    .rst_n    (reset),
    .i_btn    (btn_mode),
    .o_accept (w_modeAcc)
  );

  btn_press #(.HOLDOFF_CYCLES(HOLDOFF_CYCLES)) u_btnInc (
    .clk      (clk),
    .rst_n    (reset),
    .i_btn    (btn_inc),
    .o_accept (w_incAcc)
  );

  btn_press #(.HOLDOFF_CYCLES(HOLDOFF_CYCLES)) u_btnAck (
    .clk      (clk),
    .rst_n    (reset),
    .i_btn    (btn_ack),
    .o_accept (w_ackAcc)
  );

  assign w_remindRise  = remind & ~r_remindPrev;
  assign w_blinkCntInc = r_blinkCnt + 8'd1;
  assign w_alertCntInc = r_alertCnt + 8'd1;

  // The counter chain must advance on the same clk as tick, so this stays combinational.
  assign count_en = tick && ((r_state == RUN) || (r_state == ALERT));
  assign mode     = r_state;

  // Next-state decode; mode beats inc, and a remind edge (or pending request) beats mode in RUN.
  always_comb begin
    w_nextState      = r_state;
    w_setPending     = 1'b0;
    w_clrPending     = 1'b0;
    w_incHoursNext   = 1'b0;
    w_incMinutesNext = 1'b0;
    w_clearSecNext   = 1'b0;
    w_alertTimeout   = 1'b0;
    case (r_state)
      RUN: begin
        if (w_remindRise || r_pending) begin
          w_nextState  = ALERT;
          w_clrPending = 1'b1;
        end else if (w_modeAcc) begin
          w_nextState = PAUSE;
        end
      end
      PAUSE: begin
        if (w_modeAcc) begin
          w_nextState = SET_HR;
        end else if (w_incAcc) begin
          w_nextState = RUN;
        end
      end
      SET_HR: begin
        if (w_modeAcc) begin
          w_nextState = SET_MIN;
        end else if (w_incAcc) begin
          w_incHoursNext = 1'b1;
        end
      end
      SET_MIN: begin
        if (w_modeAcc) begin
          w_nextState    = RUN;
          w_clearSecNext = 1'b1;
        end else if (w_incAcc) begin
          w_incMinutesNext = 1'b1;
        end
      end
      ALERT: begin
        if (w_ackAcc) begin
          w_nextState = RUN;
        end else if (tick && (w_alertCntInc == 8'(ALERT_TICKS))) begin
          w_nextState    = RUN;
          w_alertTimeout = 1'b1;
        end
      end
      default: begin
        w_nextState = RUN;
      end
    endcase
    if ((r_state != RUN) && (r_state != ALERT) && w_remindRise) begin
      w_setPending = 1'b1;
    end
  end

  // State, deferred-reminder flag and remind edge history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= RUN;
      r_pending    <= 1'b0;
      r_remindPrev <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_remindPrev <= remind;
      if (w_clrPending) begin
        r_pending <= 1'b0;
      end else if (w_setPending) begin
        r_pending <= 1'b1;
      end
    end
  end

  // One-cycle field strobes and the alert drive, registered from the decode above.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inc_hours     <= 1'b0;
      inc_minutes   <= 1'b0;
      clear_seconds <= 1'b0;
      alert         <= 1'b0;
    end else begin
      inc_hours     <= w_incHoursNext;
      inc_minutes   <= w_incMinutesNext;
      clear_seconds <= w_clearSecNext;
      alert         <= (w_nextState == ALERT);
    end
  end

  // Blink phase: restarts on entering a set mode, held low everywhere else.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_blinkCnt <= 8'd0;
      blink      <= 1'b0;
    end else if (!isSetMode(w_nextState) || (w_nextState != r_state)) begin
      r_blinkCnt <= 8'd0;
      blink      <= 1'b0;
    end else if (tick) begin
      if (w_blinkCntInc == 8'(BLINK_TICKS)) begin
        r_blinkCnt <= 8'd0;
        blink      <= ~blink;
      end else begin
        r_blinkCnt <= w_blinkCntInc;
      end
    end
  end

  // Alert duration counter and the saturating tally of alerts nobody acknowledged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alertCnt <= 8'd0;
      missed     <= 4'd0;
    end else begin
      if ((r_state != ALERT) && (w_nextState == ALERT)) begin
        r_alertCnt <= 8'd0;
      end else if ((r_state == ALERT) && tick) begin
        r_alertCnt <= w_alertCntInc;
      end
      if (w_alertTimeout && (missed != 4'(MISSED_MAX))) begin
        missed <= missed + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_timer_mode_ctrl.sv
// Directed bench for timer_mode_ctrl with hand-computed expectations.
module tb_timer_mode_ctrl;
  import timer_pkg::*;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_ack;
  logic       remind;
  logic       count_en;
  logic       inc_hours;
  logic       inc_minutes;
  logic       clear_seconds;
  logic [2:0] mode;
  logic       blink;
  logic       alert;
  logic [3:0] missed;

  int checks = 0;
  int errors = 0;
  int ceCnt  = 0;
  int hrCnt  = 0;
  int minCnt = 0;
  int clrCnt = 0;
  int ceBase, hrBase, minBase, clrBase;

  timer_mode_ctrl #(
    .HOLDOFF_CYCLES (4),
    .BLINK_TICKS    (1),
    .ALERT_TICKS    (30)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tick          (tick),
    .btn_mode      (btn_mode),
    .btn_inc       (btn_inc),
    .btn_ack       (btn_ack),
    .remind        (remind),
    .count_en      (count_en),
    .inc_hours     (inc_hours),
    .inc_minutes   (inc_minutes),
    .clear_seconds (clear_seconds),
    .mode          (mode),
    .blink         (blink),
    .alert         (alert),
    .missed        (missed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tally strobe and enable cycles, sampled mid-cycle.
  always @(negedge clk) begin
    if (count_en === 1'b1) ceCnt++;
    if (inc_hours === 1'b1) hrCnt++;
    if (inc_minutes === 1'b1) minCnt++;
    if (clear_seconds === 1'b1) clrCnt++;
  end

  // Drive one clk cycle of inputs, then park just after the falling edge for sampling.
  task automatic applyStimulus(input logic m, input logic i, input logic a,
                               input logic r, input logic t);
    @(posedge clk);
    #1;
    btn_mode = m;
    btn_inc  = i;
    btn_ack  = a;
    remind   = r;
    tick     = t;
    @(negedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic snapshot();
    ceBase  = ceCnt;
    hrBase  = hrCnt;
    minBase = minCnt;
    clrBase = clrCnt;
  endtask

  initial begin
    reset    = 1'b0;
    tick     = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_ack  = 1'b0;
    remind   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    tick = 1'b1;
    #1;
    checkOutput("rst_mode", mode, RUN);
    checkOutput("rst_count_en", count_en, 1);
    checkOutput("rst_alert", alert, 0);
    checkOutput("rst_missed", missed, 0);
    checkOutput("rst_strobes", {inc_hours, inc_minutes, clear_seconds, blink}, 0);
    tick  = 1'b0;
    reset = 1'b1;
    $display("[TB] reset released");

    // Free-running: tick every 5 clk over 50 clk
    snapshot();
    for (int c = 0; c < 50; c++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, (c % 5 == 0));
    checkOutput("run_count_en_cycles", ceCnt - ceBase, 10);
    checkOutput("run_no_strobes", (hrCnt - hrBase) + (minCnt - minBase) + (clrCnt - clrBase), 0);
    checkOutput("run_mode", mode, RUN);

    // Full time-set walk
    snapshot();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("pause_mode", mode, PAUSE);
    checkOutput("pause_count_en", count_en, 0);
    idleCycles(5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("sethr_mode", mode, SET_HR);
    checkOutput("sethr_blink_entry", blink, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("sethr_blink_toggle", blink, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("inc_hours_pulse", inc_hours, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("inc_hours_one_cycle", inc_hours, 0);
      idleCycles(7);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("setmin_mode", mode, SET_MIN);
    checkOutput("setmin_blink_entry", blink, 0);
    idleCycles(5);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("inc_minutes_pulse", inc_minutes, 1);
      idleCycles(8);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("setmin_exit_mode", mode, RUN);
    checkOutput("clear_seconds_pulse", clear_seconds, 1);
    checkOutput("run_blink_forced", blink, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("clear_seconds_one_cycle", clear_seconds, 0);
    checkOutput("walk_stays_run", mode, RUN);
    checkOutput("walk_hr_count", hrCnt - hrBase, 3);
    checkOutput("walk_min_count", minCnt - minBase, 2);
    checkOutput("walk_clr_count", clrCnt - clrBase, 1);
    idleCycles(6);

    // Holdoff: btn_inc chattering in SET_HR
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycles(6);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("chatter_mode", mode, SET_HR);
    idleCycles(6);
    snapshot();
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, (k % 2 == 0), 1'b0, 1'b0, 1'b0);
    idleCycles(2);
    checkOutput("chatter_hr_count", hrCnt - hrBase, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycles(6);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("chatter_exit_mode", mode, RUN);
    idleCycles(6);

    // Remind beats a simultaneous mode press; acknowledged after 3 ticks
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("remind_alert_mode", mode, ALERT);
    checkOutput("remind_alert_out", alert, 1);
    checkOutput("alert_count_en", count_en, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ack_mode", mode, RUN);
    checkOutput("ack_alert", alert, 0);
    checkOutput("ack_missed", missed, 0);
    idleCycles(6);

    // Unacknowledged alert times out on the 30th tick
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 29; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("timeout_29_alert", alert, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("timeout_30_still_alert", alert, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("timeout_alert_drop", alert, 0);
    checkOutput("timeout_mode", mode, RUN);
    checkOutput("timeout_missed_1", missed, 1);
    for (int it = 2; it <= 17; it++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 30; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("missed_saturate", missed, (it > 15) ? 15 : it);
    end

    // Remind deferred in SET_MIN until the return to RUN
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycles(6);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycles(6);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("pend_setmin_mode", mode, SET_MIN);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("pend_no_alert_mode", mode, SET_MIN);
    checkOutput("pend_no_alert", alert, 0);
    idleCycles(5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("pend_run_mode", mode, RUN);
    checkOutput("pend_run_alert", alert, 0);
    checkOutput("pend_run_clear_seconds", clear_seconds, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("pend_alert_mode", mode, ALERT);
    checkOutput("pend_alert_out", alert, 1);

    // Asynchronous reset in the middle of an alert
    reset = 1'b0;
    #1;
    checkOutput("midrst_mode", mode, RUN);
    checkOutput("midrst_alert", alert, 0);
    checkOutput("midrst_missed", missed, 0);
    reset = 1'b1;
    idleCycles(2);
    checkOutput("postrst_mode", mode, RUN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_mode_ctrl.md
# timer_mode_ctrl

Mode controller for the water-reminder timer. It sequences the BCD time-of-day counter chain through run, pause and time-set modes, and it owns the reminder alert/acknowledge cycle. It sits between the board buttons, the selected time-base tick and the counter chain. It drives the counter advance enable, the per-field increment and clear strobes, the digit-blink flag and the alert output.

## Interface
- HOLDOFF_CYCLES, 4: clk cycles a button is ignored after an accepted press (debounce lockout); range 1..255.
- BLINK_TICKS, 1: ticks per blink half-period in set modes; range 1..255.
- ALERT_TICKS, 30: ticks an unacknowledged alert stays active; range 1..255.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- tick  in  1  one-cycle pulse at the selected time base (1 Hz / 60 Hz / 3600 Hz prescaler output).
- btn_mode  in  1  mode button, already synchronised, active high.
- btn_inc  in  1  increment/resume button, synchronised, active high.
- btn_ack  in  1  alert acknowledge button, synchronised, active high.
- remind  in  1  level from reminder logic; its rising edge requests an alert.
- count_en  out  1  advance the seconds LSD this cycle.
- inc_hours  out  1  one-cycle strobe: hours field +1 (wraps 23->00 in counter chain).
- inc_minutes  out  1  one-cycle strobe: minutes field +1 (wraps 59->00).
- clear_seconds  out  1  one-cycle strobe: seconds digits to 00.
- mode  out  3  current state encoding (mode_t).
- blink  out  1  blank the field being edited when 1.
- alert  out  1  buzzer/LED drive.
- missed  out  4  saturating count of timed-out alerts.

## Operation
- Press detection is done per button. A press is accepted on a 0->1 input edge when that button's holdoff counter is 0. Acceptance loads the counter with HOLDOFF_CYCLES, and the counter decrements every clk. Edges that arrive during holdoff are discarded.
- Same-cycle priority: btn_mode beats btn_inc, and the losing press is dropped. btn_ack is acted on only in ALERT; in other states it is accepted for holdoff purposes and otherwise ignored.
- States:
  - RUN: count_en = tick. Accepted mode press goes to PAUSE.
  - PAUSE: count_en = 0. Mode press goes to SET_HR. Inc press goes to RUN.
  - SET_HR: inc press pulses inc_hours. Mode press goes to SET_MIN.
  - SET_MIN: inc press pulses inc_minutes. Mode press goes to RUN, and clear_seconds pulses on that transition.
  - ALERT: count_en = tick and alert = 1. Ack goes to RUN. When ALERT_TICKS ticks elapse without an ack, the block goes to RUN and missed increments, saturating at 15. Mode and inc presses are ignored in ALERT.
- Rising edge of remind:
  - In RUN, it moves the block to ALERT. This beats a simultaneous mode press.
  - In any other state, it sets pending.
  - On any transition into RUN with pending = 1, the block moves to ALERT on the next clk and clears pending.
  - A remind edge while already in ALERT is ignored.
- Blink counter:
  - Cleared on entry to SET_HR or SET_MIN.
  - Counts ticks. blink toggles every BLINK_TICKS ticks and wraps to 0.
  - blink is forced to 0 outside the set states.
- Alert tick counter is cleared on ALERT entry and counts ticks. Timeout fires on the tick that brings the count to ALERT_TICKS.

## Timing
- Reset values: state RUN, count_en follows tick (RUN), inc_hours / inc_minutes / clear_seconds / blink / alert = 0, missed = 0, pending = 0, all holdoff counters = 0, remind edge register = 0.
- count_en is combinational from tick and registered state, with zero latency, so the counter chain advances on the same clk as tick.
- All other outputs are registered. A press accepted in cycle N changes state at the end of N, and its strobe is high for exactly cycle N+1. The mode and alert outputs reflect the new state in N+1.
- Back-to-back inc presses are HOLDOFF_CYCLES + 1 apart at minimum, and each yields exactly one strobe.
- Reset asserted mid-operation clears everything immediately. Any in-flight strobe is dropped, and the counter chain is reset on the same reset.

## Structure
- Shared timer_pkg holds:
  - mode_t enum: RUN=0, PAUSE=1, SET_HR=2, SET_MIN=3, ALERT=4.
  - MISSED_MAX = 15.
- Sub-module btn_press: one button with edge detect and holdoff counter, output accept pulse, parameter HOLDOFF_CYCLES. It is instantiated 3x.
- FSM, blink counter and alert timer live in timer_mode_ctrl.

## Test plan
- Reset release, then tick every 5 clk for 50 clk: mode=RUN, count_en high on exactly 10 cycles, all strobes 0.
- mode press x2, then 3 inc presses spaced 10 clk, then mode, then 2 inc, then mode: inc_hours pulses 3 times, inc_minutes pulses 2 times, clear_seconds pulses once, and mode returns to RUN.
- btn_inc toggled 0/1 every clk for 8 clk in SET_HR with HOLDOFF_CYCLES=4: exactly 2 inc_hours pulses.
- remind rises in RUN together with a mode press: next cycle mode=ALERT and alert=1. Ack after 3 ticks: RUN, missed=0.
- remind rises, no ack, ALERT_TICKS=30: alert drops on the 30th tick and missed=1. Repeat 17 times: missed saturates at 15.
- remind rises in SET_MIN: no alert yet. Mode press gives RUN for 1 cycle, then ALERT.
